// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and the cell grid / user input logic.
// The sequencer side uses the master modport.
interface game_sequencer_if;
    logic       new_game;
    logic       fire_in;
    logic [3:0] sel_row;
    logic [3:0] sel_col;
    logic       sel_error;
    logic       board_won;
    logic [3:0] row_en;
    logic [3:0] col_en;
    logic       fire_out;
    logic       busy;
    logic       buzz;
    logic [7:0] move_count;
    logic [2:0] state;

    modport master (
        input  new_game, fire_in, sel_row, sel_col, sel_error, board_won,
        output row_en, col_en, fire_out, busy, buzz, move_count, state
    );

    modport slave (
        output new_game, fire_in, sel_row, sel_col, sel_error, board_won,
        input  row_en, col_en, fire_out, busy, buzz, move_count, state
    );
endinterface

// File: rtl/game_sequencer.sv
// 4x4 grid game controller: LFSR scramble batches, user move forwarding with a
// saturating move counter, and a timed buzzer request once the board is solved.
module game_sequencer #(
    parameter int unsigned SCRAMBLE_MOVES = 8,
    parameter int unsigned WIN_HOLD       = 100_000_000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCRAMBLE = 3'd1,
        SETTLE   = 3'd2,
        PLAY     = 3'd3,
        WON      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_FIRE  = 2'd1,
        PH_GAP   = 2'd2
    } phase_t;

    localparam int unsigned       HOLD_W     = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(WIN_HOLD - 1);
    localparam logic [7:0]        MOVES_LAST = 8'(SCRAMBLE_MOVES - 1);

    state_t            state_q;
    phase_t            phase_q;
    logic [7:0]        batch_q;
    logic [7:0]        move_count_q;
    logic              settle_q;
    logic [HOLD_W-1:0] hold_q;
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_d;
    logic              ng_q, ng_prev_q;
    logic              fi_q, fi_prev_q;
    logic              bw_q;
    logic [3:0]        row_en_q, col_en_q;
    logic              fire_q, busy_q, buzz_q;

    logic       ng_edge, fi_edge, legal, win, start_batch;
    logic [3:0] scr_row_d, scr_col_d, sel_row_d, sel_col_d;

    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        ng_edge   = ng_q & ~ng_prev_q;
        fi_edge   = fi_q & ~fi_prev_q;
        legal     = ~bus.sel_error & ((|bus.sel_row) ^ (|bus.sel_col));
        win       = bus.board_won & bw_q;
        scr_row_d = lfsr_q[2] ? 4'b0000 : (4'b0001 << lfsr_q[1:0]);
        scr_col_d = lfsr_q[2] ? (4'b0001 << lfsr_q[1:0]) : 4'b0000;
        sel_row_d = bus.sel_error ? 4'b0000 : bus.sel_row;
        sel_col_d = bus.sel_error ? 4'b0000 : bus.sel_col;
        // A batch starts on a user new-game edge, or when SETTLE still sees a solved board.
        start_batch = (ng_edge && (state_q == IDLE || state_q == PLAY || state_q == WON))
                   || (state_q == SETTLE && settle_q && bus.board_won);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            phase_q      <= PH_SETUP;
            batch_q      <= '0;
            move_count_q <= '0;
            settle_q     <= 1'b0;
            hold_q       <= '0;
            lfsr_q       <= LFSR_SEED;
            ng_q         <= 1'b0;
            ng_prev_q    <= 1'b0;
            fi_q         <= 1'b0;
            fi_prev_q    <= 1'b0;
            bw_q         <= 1'b0;
            row_en_q     <= '0;
            col_en_q     <= '0;
            fire_q       <= 1'b0;
            busy_q       <= 1'b0;
            buzz_q       <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            ng_q      <= bus.new_game;
            ng_prev_q <= ng_q;
            fi_q      <= bus.fire_in;
            fi_prev_q <= fi_q;
            bw_q      <= bus.board_won;
            fire_q    <= 1'b0;

            if (start_batch) begin
                if (state_q != SETTLE) move_count_q <= '0;
                batch_q  <= '0;
                phase_q  <= PH_SETUP;
                settle_q <= 1'b0;
                busy_q   <= 1'b1;
                buzz_q   <= 1'b0;
                if (SCRAMBLE_MOVES == 0) begin
                    state_q  <= SETTLE;
                    row_en_q <= '0;
                    col_en_q <= '0;
                end else begin
                    state_q  <= SCRAMBLE;
                    row_en_q <= scr_row_d;
                    col_en_q <= scr_col_d;
                end
            end else begin
                case (state_q)
                    SCRAMBLE: begin
                        case (phase_q)
                            PH_SETUP: begin
                                phase_q <= PH_FIRE;
                                fire_q  <= 1'b1;
                            end
                            PH_FIRE: begin
                                phase_q  <= PH_GAP;
                                row_en_q <= '0;
                                col_en_q <= '0;
                            end
                            default: begin
                                if (batch_q == MOVES_LAST) begin
                                    state_q  <= SETTLE;
                                    settle_q <= 1'b0;
                                end else begin
                                    batch_q  <= batch_q + 8'd1;
                                    phase_q  <= PH_SETUP;
                                    row_en_q <= scr_row_d;
                                    col_en_q <= scr_col_d;
                                end
                            end
                        endcase
                    end
                    SETTLE: begin
                        if (!settle_q) begin
                            settle_q <= 1'b1;
                        end else begin
                            state_q  <= PLAY;
                            busy_q   <= 1'b0;
                            row_en_q <= sel_row_d;
                            col_en_q <= sel_col_d;
                        end
                    end
                    PLAY: begin
                        // A completed win outranks a simultaneous fire edge.
                        if (win) begin
                            state_q  <= WON;
                            buzz_q   <= 1'b1;
                            hold_q   <= '0;
                            row_en_q <= '0;
                            col_en_q <= '0;
                        end else begin
                            row_en_q <= sel_row_d;
                            col_en_q <= sel_col_d;
                            if (fi_edge && legal) begin
                                fire_q <= 1'b1;
                                if (move_count_q != 8'hFF) move_count_q <= move_count_q + 8'd1;
                            end
                        end
                    end
                    WON: begin
                        if (hold_q == HOLD_LAST) begin
                            state_q <= IDLE;
                            buzz_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    default: begin
                        row_en_q <= '0;
                        col_en_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.row_en     = row_en_q;
    assign bus.col_en     = col_en_q;
    assign bus.fire_out   = fire_q;
    assign bus.busy       = busy_q;
    assign bus.buzz       = buzz_q;
    assign bus.move_count = move_count_q;
    assign bus.state      = state_q;
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Controller that sequences the 4x4 cell grid. Owns the single fire strobe and the row/column enable buses into all sixteen cells. Scrambles the board with pseudo-random moves at the start of a game, then forwards user moves as one-cycle fire pulses and counts them. Detects the solved board from the win checker and holds the buzzer request for a fixed time.

## Interface
- SCRAMBLE_MOVES, 8: moves issued per scramble batch, range 0..255.
- WIN_HOLD, 100_000_000: cycles `buzz` stays high in WON. Must be ≥1.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset. Must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- new_game  in  1  debounced level; a rising edge starts a game
- fire_in  in  1  debounced user fire level
- sel_row  in  4  user row select, one-hot or zero
- sel_col  in  4  user column select, one-hot or zero
- sel_error  in  1  switch error from the row/column input checker
- board_won  in  1  win-checker level
- row_en  out  4  row enables to the cells
- col_en  out  4  column enables to the cells
- fire_out  out  1  one-cycle fire strobe to all cells
- busy  out  1  high in SCRAMBLE or SETTLE
- buzz  out  1  sound request, high in WON
- move_count  out  8  user moves this game, saturates at 255
- state  out  3  IDLE=0, SCRAMBLE=1, SETTLE=2, PLAY=3, WON=4

## Operation
- Edge detect: `new_game` and `fire_in` are each registered once. A rising edge means current=1 and previous=0.
- LFSR: 16-bit Galois, mask 16'hB400. Shifts right every cycle in every state. It is never reseeded except by reset.
- IDLE:
  - All outputs 0.
  - A `new_game` edge clears `move_count` and the batch counter, then goes to SCRAMBLE.
- SCRAMBLE: each move is 3 cycles.
  - SETUP: drive enables from the LFSR sampled on entry. If bit2=0, `row_en` is one-hot at index lfsr[1:0] and `col_en`=0. Otherwise `col_en` is one-hot at index lfsr[1:0] and `row_en`=0.
  - FIRE: same enables, `fire_out`=1.
  - GAP: enables 0.
  - After SCRAMBLE_MOVES moves, go to SETTLE. With SCRAMBLE_MOVES=0, go straight to SETTLE.
  - `fire_in` and `new_game` edges are ignored.
- SETTLE: wait 2 cycles with all enables 0, then sample `board_won`.
  - If 1, run another SCRAMBLE batch: counter cleared, LFSR continues.
  - Otherwise go to PLAY.
- PLAY:
  - `row_en`=`sel_row` and `col_en`=`sel_col`, both forced to 0 when `sel_error`=1.
  - A `fire_in` edge is a legal move when `sel_error`=0 and exactly one of `sel_row`/`sel_col` is nonzero. A legal move produces a `fire_out` pulse the next cycle and increments `move_count`, saturating at 255.
  - A `fire_in` edge that is not a legal move is dropped with no count.
  - `board_won`=1 on 2 consecutive cycles goes to WON.
  - Win priority: when the win condition completes in the same cycle as a fire edge, go to WON and suppress the fire.
  - A `new_game` edge abandons the game, clears `move_count` and goes to SCRAMBLE.
- WON:
  - Enables 0, `fire_out`=0, `buzz`=1. The hold counter counts WIN_HOLD cycles, then the block returns to IDLE with `buzz`=0.
  - `move_count` is held until the next game starts.
  - A `new_game` edge goes to SCRAMBLE immediately, drops `buzz` and clears `move_count`.

## Timing
- Reset asserted, any state:
  - All outputs 0 and `state`=IDLE.
  - LFSR=LFSR_SEED.
  - Edge registers are 0. A level already high at reset release therefore registers as an edge.
  - All counters are 0.
- All outputs are registered, with no combinational input-to-output paths.
- Latency, `new_game` edge: input high at clock edge k gives `state`=SCRAMBLE and `busy`=1 at edge k+1.
- Latency, legal `fire_in` edge: input high at clock edge k gives `fire_out`=1 for exactly the cycle after edge k+1.
- `fire_out` is never high on two consecutive cycles.
- Enables are stable for at least 1 cycle before and during every scramble `fire_out`.
- Scramble batch duration: 3·SCRAMBLE_MOVES cycles, plus 2 cycles of SETTLE.

## Test plan
- Reset check: SCRAMBLE_MOVES=2, seed 16'hACE1, `reset` low mid-SCRAMBLE.
  - Outputs go 0 asynchronously.
  - After release and a `new_game` edge, exactly 2 `fire_out` pulses occur, `busy` is high for 8 cycles, and enables match the reference-model LFSR.
- Resample on solved board: `board_won`=1 through SETTLE → a second scramble batch runs (2 more pulses). Dropping `board_won` → PLAY, `state`=3.
- User moves in PLAY:
  - Fire edge with `sel_row`=4'b0100, `sel_col`=0 → one `fire_out` pulse with `row_en`=4'b0100, `move_count`=1.
  - Same edge with `sel_error`=1, or with both selects nonzero → no pulse, count unchanged.
  - Holding `fire_in` high for 100 cycles → one pulse only.
- Saturation: 300 legal moves → `move_count`=255.
- Win handling: WIN_HOLD=5.
  - `board_won` high 1 cycle → stays PLAY.
  - High 2 cycles in the same cycle as a fire edge → WON, no pulse, `buzz` high 5 cycles, then IDLE with the count held.
- Restart from WON: `new_game` edge during WON → `buzz` drops next cycle, `move_count`=0, `state`=SCRAMBLE.
